// File: rtl/uart_cfg.sv
// uart_cfg: parametrised full-duplex UART.
// The TX side sends start, LSB-first data, optional parity and 1 or 2 stop bits, each bit TX_DIV cycles long.
// The RX side oversamples a synchronised rx line, rejects false starts,
// and reports parity, framing and overrun errors.
module uart_cfg #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic                 rdy,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TX_DIV = CLK_HZ / BAUD;
  localparam int RX_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TXC_W  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int RXC_W  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int OS_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TXC_W-1:0] TX_LAST   = TXC_W'(TX_DIV - 1);
  localparam logic [RXC_W-1:0] RX_LAST   = RXC_W'(RX_DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (TX_DIV < 1 || RX_DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_params
    $error("uart_cfg: illegal parameter set");
  end

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t            tx_state_q, tx_state_d;
  logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_tick;

  rx_state_t            rx_state_q, rx_state_d;
  logic [RXC_W-1:0]     rx_div_q, rx_div_d;
  logic [OS_W-1:0]      rx_os_q, rx_os_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rdy_q, rdy_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic                 rx_tick, rx_sample, rx_active, rx_par_bad;

  // TX next state: one bit every TX_DIV cycles, line level registered from the next state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_tick    = (tx_cnt_q == TX_LAST);
    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: begin
        if (wr_en) begin
          tx_shift_d = din;
          tx_par_d   = (PARITY == 1) ? ~(^din) : (^din);
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d   = '0;
            tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_tick) begin
          tx_bit_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // TX state registers; reset returns the line to idle high at once
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // Two-flop synchroniser for rx plus one delayed copy for falling-edge detection
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // RX next state: oversample ticks, bit-centre sampling, result and error flag update
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_div_d     = rx_div_q;
    rx_os_d      = rx_os_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_d     = rx_par_q;
    rdy_d        = rdy_q;
    dout_d       = dout_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    rx_sample    = 1'b0;
    rx_tick      = (rx_div_q == RX_LAST);
    rx_par_bad   = ((^{rx_shift_q, rx_par_q}) != (PARITY == 1));
    rx_active    = (rx_state_q == RX_START) || (rx_state_q == RX_DATA) ||
                   (rx_state_q == RX_PARITY) || (rx_state_q == RX_STOP);
    if (rx_active) begin
      rx_div_d = rx_tick ? '0 : rx_div_q + 1'b1;
      if (rx_tick) begin
        if (rx_os_q == ((rx_state_q == RX_START) ? OS_HALF : OS_LAST)) begin
          rx_sample = 1'b1;
          rx_os_d   = '0;
        end else begin
          rx_os_d = rx_os_q + 1'b1;
        end
      end
    end
    if (rdy_clr) begin
      rdy_d        = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          rx_div_d   = '0;
          rx_os_d    = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_sample) begin
          rx_bit_d   = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_d   = rx_s_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          if (!rdy_q || rdy_clr) begin
            dout_d       = rx_shift_q;
            rdy_d        = 1'b1;
            parity_err_d = (PARITY != 0) && rx_par_bad;
            frame_err_d  = !rx_s_q;
            overrun_d    = 1'b0;
          end else begin
            overrun_d = 1'b1;
          end
          rx_state_d = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state and result registers
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      rx_div_q     <= '0;
      rx_os_q      <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= 1'b0;
      rdy_q        <= 1'b0;
      dout_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_div_q     <= rx_div_d;
      rx_os_q      <= rx_os_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_q     <= rx_par_d;
      rdy_q        <= rdy_d;
      dout_q       <= dout_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign rdy        = rdy_q;
  assign dout       = dout_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: directed tests for uart_cfg in 8N1, 8E1 and 8N2 configurations
// (TX_DIV=16, RX_DIV=1, 16x oversampling).
module tb_uart_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       rdy_clr = 1'b0;
  logic       rx_drv = 1'b1;
  logic       wr_n1 = 1'b0, wr_e1 = 1'b0, wr_n2 = 1'b0;
  logic       loop_n1 = 1'b0, loop_n2 = 1'b0;

  logic       tx_n1, busy_n1, rdy_n1, pe_n1, fe_n1, ov_n1;
  logic       tx_e1, busy_e1, rdy_e1, pe_e1, fe_e1, ov_e1;
  logic       tx_n2, busy_n2, rdy_n2, pe_n2, fe_n2, ov_n2;
  logic [7:0] dout_n1, dout_e1, dout_n2;
  logic       rx_n1, rx_n2;

  int vectors = 0;
  int miscompares = 0;

  int         rises_n1 = 0;
  int         errcyc_n1 = 0;
  logic       prev_n1 = 1'b0;
  logic       prev_n2 = 1'b0;
  logic [7:0] log_n2[$];

  assign rx_n1 = loop_n1 ? tx_n1 : rx_drv;
  assign rx_n2 = loop_n2 ? tx_n2 : rx_drv;

  uart_cfg #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16))
    u_n1 (.clk_50m(clk), .rst(rst), .din(din), .wr_en(wr_n1), .tx(tx_n1), .tx_busy(busy_n1),
          .rx(rx_n1), .rdy(rdy_n1), .rdy_clr(rdy_clr), .dout(dout_n1),
          .parity_err(pe_n1), .frame_err(fe_n1), .overrun(ov_n1));

  uart_cfg #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16))
    u_e1 (.clk_50m(clk), .rst(rst), .din(din), .wr_en(wr_e1), .tx(tx_e1), .tx_busy(busy_e1),
          .rx(rx_drv), .rdy(rdy_e1), .rdy_clr(rdy_clr), .dout(dout_e1),
          .parity_err(pe_e1), .frame_err(fe_e1), .overrun(ov_e1));

  uart_cfg #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16))
    u_n2 (.clk_50m(clk), .rst(rst), .din(din), .wr_en(wr_n2), .tx(tx_n2), .tx_busy(busy_n2),
          .rx(rx_n2), .rdy(rdy_n2), .rdy_clr(rdy_clr), .dout(dout_n2),
          .parity_err(pe_n2), .frame_err(fe_n2), .overrun(ov_n2));

  // 100 MHz-style free-running clock; the design is active on the rising edge
  always #5 clk = ~clk;

  // Count 8N1 rdy rising edges and error-flag cycles; log 8N2 received bytes
  always @(negedge clk) begin
    prev_n1 <= rdy_n1;
    prev_n2 <= rdy_n2;
    if (rdy_n1 && !prev_n1) rises_n1++;
    if (pe_n1 || fe_n1 || ov_n1) errcyc_n1++;
    if (rdy_n2 && !prev_n2) log_n2.push_back(dout_n2);
  end

  // Hard stop if something hangs despite the bounded waits
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    wr_n1 = 1'b0; wr_e1 = 1'b0; wr_n2 = 1'b0;
    rdy_clr = 1'b0; rx_drv = 1'b1; loop_n1 = 1'b0; loop_n2 = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic drive_frame(input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = bits[i];
      repeat (16) step();
    end
  endtask

  task automatic test_reset();
    logic [13:0] exp_v;
    exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 3'b000};
    rst = 1'b1;
    repeat (2) step();
    vectors++;
    if ({tx_n1, busy_n1, rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1} !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL reset_n1: got %h, expected %h", {tx_n1, busy_n1, rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1}, exp_v);
    end
    vectors++;
    if ({tx_e1, busy_e1, rdy_e1, dout_e1, pe_e1, fe_e1, ov_e1} !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL reset_e1: got %h, expected %h", {tx_e1, busy_e1, rdy_e1, dout_e1, pe_e1, fe_e1, ov_e1}, exp_v);
    end
    vectors++;
    if ({tx_n2, busy_n2, rdy_n2, dout_n2, pe_n2, fe_n2, ov_n2} !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL reset_n2: got %h, expected %h", {tx_n2, busy_n2, rdy_n2, dout_n2, pe_n2, fe_n2, ov_n2}, exp_v);
    end
    apply_reset();
  endtask

  task automatic test_loopback_8n1();
    int base_r, base_e, waited;
    apply_reset();
    loop_n1 = 1'b1;
    step();
    base_r = rises_n1;
    base_e = errcyc_n1;
    for (int b = 0; b < 256; b++) begin
      din = b[7:0];
      wr_n1 = 1'b1;
      step();
      wr_n1 = 1'b0;
      waited = 0;
      while (!rdy_n1 && waited < 400) begin step(); waited++; end
      vectors++;
      if (rdy_n1 !== 1'b1 || dout_n1 !== b[7:0]) begin
        miscompares++;
        $display("[TB] FAIL loop_byte: got rdy=%b dout=%h, expected rdy=1 dout=%h", rdy_n1, dout_n1, b[7:0]);
      end
      rdy_clr = 1'b1;
      step();
      rdy_clr = 1'b0;
      waited = 0;
      while (busy_n1 && waited < 200) begin step(); waited++; end
    end
    repeat (4) step();
    vectors++;
    if (rises_n1 - base_r != 256) begin
      miscompares++;
      $display("[TB] FAIL loop_rdy_count: got %0d, expected 256", rises_n1 - base_r);
    end
    vectors++;
    if (errcyc_n1 - base_e != 0) begin
      miscompares++;
      $display("[TB] FAIL loop_no_errors: got %0d flagged cycles, expected 0", errcyc_n1 - base_e);
    end
  endtask

  task automatic test_parity_8e1();
    logic [10:0] exp_bits;
    logic [11:0] exp_rx;
    int errs;
    apply_reset();
    exp_bits = {1'b1, 1'b1, 8'h01, 1'b0};
    din = 8'h01;
    wr_e1 = 1'b1;
    step();
    wr_e1 = 1'b0;
    for (int k = 0; k < 11; k++) begin
      errs = 0;
      repeat (16) begin
        if (tx_e1 !== exp_bits[k] || busy_e1 !== 1'b1) errs++;
        step();
      end
      vectors++;
      if (errs != 0) begin
        miscompares++;
        $display("[TB] FAIL e1_bit%0d: %0d of 16 cycles wrong (tx=%b busy=%b), expected tx=%b busy=1",
                 k, errs, tx_e1, busy_e1, exp_bits[k]);
      end
    end
    vectors++;
    if ({tx_e1, busy_e1} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL e1_busy_end: got tx=%b busy=%b after 176 cycles, expected tx=1 busy=0", tx_e1, busy_e1);
    end
    drive_frame({1'b1, 1'b0, 8'h01, 1'b0}, 11);
    rx_drv = 1'b1;
    repeat (4) step();
    exp_rx = {1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vectors++;
    if ({rdy_e1, dout_e1, pe_e1, fe_e1, ov_e1} !== exp_rx) begin
      miscompares++;
      $display("[TB] FAIL e1_parity_err: got %h, expected %h", {rdy_e1, dout_e1, pe_e1, fe_e1, ov_e1}, exp_rx);
    end
  endtask

  task automatic test_back_to_back();
    int cnt, base;
    logic [7:0] got;
    apply_reset();
    loop_n2 = 1'b1;
    base = log_n2.size();
    din = 8'h3C;
    wr_n2 = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      while (busy_n2 && cnt < 400) begin
        wr_n2 = (cnt == 40);
        din = (cnt == 40) ? 8'hAA : din;
        rdy_clr = rdy_n2;
        step();
        cnt++;
      end
      wr_n2 = 1'b0;
      vectors++;
      if (cnt != 176) begin
        miscompares++;
        $display("[TB] FAIL n2_frame%0d_len: got %0d busy cycles, expected 176", f, cnt);
      end
      if (f == 0) begin
        din = 8'h5A;
        wr_n2 = 1'b1;
        rdy_clr = rdy_n2;
        step();
        vectors++;
        if (busy_n2 !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL n2_idle_gap: got busy=%b one cycle after fall, expected 1", busy_n2);
        end
      end
    end
    rdy_clr = 1'b0;
    repeat (8) step();
    vectors++;
    if (log_n2.size() != base + 2) begin
      miscompares++;
      $display("[TB] FAIL n2_rx_count: got %0d bytes, expected 2", log_n2.size() - base);
    end
    got = (log_n2.size() > base) ? log_n2[base] : 8'hxx;
    vectors++;
    if (got !== 8'h3C) begin
      miscompares++;
      $display("[TB] FAIL n2_byte0: got %h, expected 3c", got);
    end
    got = (log_n2.size() > base + 1) ? log_n2[base + 1] : 8'hxx;
    vectors++;
    if (got !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL n2_byte1: got %h, expected 5a", got);
    end
    vectors++;
    if ({pe_n2, fe_n2, ov_n2} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL n2_flags: got %b, expected 000", {pe_n2, fe_n2, ov_n2});
    end
  endtask

  task automatic test_frame_error();
    int base;
    logic [11:0] exp_rx;
    apply_reset();
    base = rises_n1;
    drive_frame({1'b0, 8'h5A, 1'b0}, 10);
    repeat (4) step();
    exp_rx = {1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
    vectors++;
    if ({rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1} !== exp_rx) begin
      miscompares++;
      $display("[TB] FAIL frame_err: got %h, expected %h", {rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1}, exp_rx);
    end
    rdy_clr = 1'b1;
    step();
    rdy_clr = 1'b0;
    repeat (500) step();
    rx_drv = 1'b1;
    repeat (40) step();
    vectors++;
    if (rises_n1 - base != 1 || rdy_n1 !== 1'b0 || fe_n1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL line_break: got rises=%0d rdy=%b fe=%b, expected rises=1 rdy=0 fe=0",
               rises_n1 - base, rdy_n1, fe_n1);
    end
  endtask

  task automatic test_glitch_overrun();
    logic [11:0] exp_rx;
    apply_reset();
    rx_drv = 1'b0;
    repeat (5) step();
    rx_drv = 1'b1;
    repeat (200) step();
    vectors++;
    if (rdy_n1 !== 1'b0 || fe_n1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL glitch: got rdy=%b fe=%b, expected 0 0", rdy_n1, fe_n1);
    end
    drive_frame({1'b1, 8'h11, 1'b0}, 10);
    rx_drv = 1'b1;
    repeat (16) step();
    exp_rx = {1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    vectors++;
    if ({rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1} !== exp_rx) begin
      miscompares++;
      $display("[TB] FAIL first_frame: got %h, expected %h", {rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1}, exp_rx);
    end
    drive_frame({1'b1, 8'h22, 1'b0}, 10);
    rx_drv = 1'b1;
    repeat (16) step();
    exp_rx = {1'b1, 8'h11, 1'b0, 1'b0, 1'b1};
    vectors++;
    if ({rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1} !== exp_rx) begin
      miscompares++;
      $display("[TB] FAIL overrun: got %h, expected %h", {rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1}, exp_rx);
    end
  endtask

  task automatic test_reset_midframe();
    int waited;
    logic [11:0] exp_rx;
    apply_reset();
    loop_n1 = 1'b1;
    din = 8'h96;
    wr_n1 = 1'b1;
    step();
    wr_n1 = 1'b0;
    repeat (70) step();
    vectors++;
    if ({tx_n1, busy_n1} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL mid_bit3: got tx=%b busy=%b, expected tx=0 busy=1", tx_n1, busy_n1);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({tx_n1, busy_n1} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got tx=%b busy=%b, expected tx=1 busy=0", tx_n1, busy_n1);
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    din = 8'hC3;
    wr_n1 = 1'b1;
    step();
    wr_n1 = 1'b0;
    waited = 0;
    while (!rdy_n1 && waited < 400) begin step(); waited++; end
    exp_rx = {1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
    vectors++;
    if ({rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1} !== exp_rx) begin
      miscompares++;
      $display("[TB] FAIL after_reset: got %h, expected %h", {rdy_n1, dout_n1, pe_n1, fe_n1, ov_n1}, exp_rx);
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_parity_8e1();
    test_back_to_back();
    test_frame_error();
    test_glitch_overrun();
    test_reset_midframe();
    test_loopback_8n1();
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
